// File: rtl/pio_stream_pkg.sv
// Shared word and stream definitions for the PIO nibble stream.
// The transmitter and the receiver both import this package.
package pio_stream_pkg;

  localparam int unsigned NIB_W            = 4;
  localparam int unsigned NIBBLES_PER_WORD = 6;
  localparam int unsigned WORD_W           = 24;
  localparam int unsigned LEN_W            = 11;
  localparam int unsigned NCNT_W           = $clog2(NIBBLES_PER_WORD);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_ASSEMBLE = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } word_entry_t;

  // A frame length of zero means a frame of one word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/pio_word_fifo.sv
// Show-ahead synchronous FIFO that holds reassembled words (tlast + data).
// When the FIFO is full, a push is accepted only if a pop happens in the same cycle.
module pio_word_fifo
  import pio_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  word_entry_t i_wr_entry,
  input  logic        i_pop,
  output word_entry_t o_rd_entry,
  output logic        o_empty,
  output logic        o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  word_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head entry reads as zero while empty, so the outputs are quiet in reset.
  assign o_rd_entry = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pio_nibble_rx.sv
// Reassembles 24-bit IQ words from a 4-bit PIO nibble stream and tags frame ends.
// Partial words are discarded after an idle timeout. Completed words are buffered for an AXI-Stream sink.
module pio_nibble_rx
  import pio_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIB_W-1:0]  us_stream,
  input  logic              us_stream_valid,
  input  logic [LEN_W-1:0]  frame_len,
  output logic [WORD_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              overflow,
  output logic              partial_drop
);

  localparam int unsigned ACC_W  = WORD_W - NIB_W;
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  rx_state_e         r_state, w_state_nxt;
  logic [NCNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [LEN_W-1:0]  r_idx, w_idx_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic              r_overflow, w_ovf_nxt;
  logic              r_partial_drop, w_pdrop_nxt;
  logic              w_push, w_pop, w_full, w_empty, w_last;
  word_entry_t       w_entry, w_rd_entry;

  assign w_pop        = m_tvalid & m_tready;
  assign m_tvalid     = ~w_empty;
  assign m_tdata      = w_rd_entry.data;
  assign m_tlast      = w_rd_entry.last;
  assign overflow     = r_overflow;
  assign partial_drop = r_partial_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_idle_nxt  = r_idle;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_ovf_nxt   = r_overflow;
    w_pdrop_nxt = 1'b0;
    w_push      = 1'b0;
    w_last      = 1'b0;
    w_entry     = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_idle_nxt = '0;
        if (us_stream_valid) begin
          w_acc_nxt   = {r_acc[ACC_W-NIB_W-1:0], us_stream};
          w_cnt_nxt   = NCNT_W'(1);
          w_state_nxt = ST_ASSEMBLE;
          // Frame length is latched only at the start of a frame.
          if (r_idx == '0) begin
            w_len_nxt = eff_len(frame_len);
          end
        end
      end
      ST_ASSEMBLE: begin
        if (us_stream_valid) begin
          w_idle_nxt = '0;
          if (r_cnt == NCNT_W'(NIBBLES_PER_WORD - 1)) begin
            w_last       = (r_idx == r_len - LEN_W'(1));
            w_entry.data = {r_acc, us_stream};
            w_entry.last = w_last;
            if (w_full && !w_pop) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_push = 1'b1;
            end
            w_idx_nxt   = w_last ? '0 : r_idx + LEN_W'(1);
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_acc_nxt = {r_acc[ACC_W-NIB_W-1:0], us_stream};
            w_cnt_nxt = r_cnt + NCNT_W'(1);
          end
        end else if (r_idle == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          w_pdrop_nxt = 1'b1;
          w_idle_nxt  = '0;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_idle_nxt = r_idle + IDLE_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_acc          <= '0;
      r_idle         <= '0;
      r_idx          <= '0;
      r_len          <= LEN_W'(1);
      r_overflow     <= 1'b0;
      r_partial_drop <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_acc          <= w_acc_nxt;
      r_idle         <= w_idle_nxt;
      r_idx          <= w_idx_nxt;
      r_len          <= w_len_nxt;
      r_overflow     <= w_ovf_nxt;
      r_partial_drop <= w_pdrop_nxt;
    end
  end

  pio_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_wr_entry (w_entry),
    .i_pop      (w_pop),
    .o_rd_entry (w_rd_entry),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

endmodule

// File: doc/pio_nibble_rx.md
PIO_NIBBLE_RX -- requirements
Module: pio_nibble_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output word buffer depth (power of two, ≥2).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 16, consecutive idle cycles tolerated mid-word before the partial word is discarded.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge (nibble stream clock).
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port us_stream  input  4  nibble data from the PIO stream transmitter.
REQ-006 SHALL have port us_stream_valid  input  1  nibble on us_stream is valid this cycle.
REQ-007 SHALL have port frame_len  input  11  words per frame (0 treated as 1).
REQ-008 SHALL have port m_tdata  output  24  reassembled IQ word.
REQ-009 SHALL have port m_tvalid  output  1  m_tdata valid.
REQ-010 SHALL have port m_tready  input  1  downstream accepts word.
REQ-011 SHALL have port m_tlast  output  1  word is last of its frame.
REQ-012 SHALL have port overflow  output  1  sticky: a completed word was dropped because the buffer was full.
REQ-013 SHALL have port partial_drop  output  1  one-cycle pulse: partial word discarded on idle timeout.

Function
REQ-014 SHALL assemble each 24-bit word from 6 valid nibbles, MSB nibble first (first nibble → bits 23:20).
REQ-015 SHALL ignore us_stream whenever us_stream_valid is low; gaps mid-word hold the nibble count.
REQ-016 SHALL use states IDLE (nibble count 0) and ASSEMBLE (count 1..5); IDLE→ASSEMBLE on a valid nibble; ASSEMBLE→IDLE on the 6th valid nibble or on timeout.
REQ-017 SHALL push the word into the buffer on the clock edge that captures the 6th nibble; m_tvalid SHALL rise on the following cycle (latency 1 cycle).
REQ-018 SHALL transfer a word when m_tvalid and m_tready are both high; m_tdata/m_tlast SHALL hold stable while m_tvalid is high and m_tready is low.
REQ-019 SHALL maintain a word index 0..L-1, with L = frame_len sampled when index is 0 and the word's first nibble arrives; the word at index L-1 SHALL carry tlast=1, after which index returns to 0.
REQ-020 SHALL, on a completed word while the buffer is full and no pop occurs that cycle, drop the word, set overflow, and still advance the word index.
REQ-021 SHALL accept a push into a full buffer when a pop occurs in the same cycle (no drop).
REQ-022 SHALL count consecutive invalid cycles in ASSEMBLE; on reaching IDLE_TIMEOUT it SHALL discard the partial word, pulse partial_drop for one cycle, reset the word index to 0, and return to IDLE.
REQ-023 SHALL clear the idle counter on every valid nibble and hold it at 0 in IDLE.
REQ-024 SHALL NOT change the sampled L mid-frame regardless of frame_len changes.

Reset
REQ-025 SHALL, while rst is high, drive m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0, partial_drop=0, empty the buffer, zero nibble count, idle counter and word index, and enter IDLE.
REQ-026 SHALL discard any partial word or frame in progress when rst asserts mid-operation, without pulsing partial_drop.
REQ-027 SHALL accept a valid nibble on the first cycle after rst deasserts.

Structure
REQ-028 SHALL take NIBBLES_PER_WORD (6), WORD_W (24) and LEN_W (11) from shared package pio_stream_pkg, which the transmitter side also uses.
REQ-029 SHALL implement the buffer as one sub-module pio_word_fifo (25-bit entries: tlast + data, synchronous, show-ahead).

Verification
REQ-030 SHALL verify: frame_len=2, nibbles 1,2,3,4,5,6 then A,B,C,D,E,F back-to-back, m_tready=1 -> words 0x123456 (tlast=0) then 0xABCDEF (tlast=1), each valid 1 cycle after its 6th nibble.
REQ-031 SHALL verify: 3 nibbles, 5-cycle valid gap, 3 nibbles -> single word assembled correctly, partial_drop stays 0.
REQ-032 SHALL verify: 2 nibbles then 16 idle cycles -> partial_drop pulses once, no word output, next 6 nibbles form a word at index 0.
REQ-033 SHALL verify: m_tready=0, 5 words (FIFO_DEPTH=4) -> 4 words retained in order, 5th dropped, overflow=1 and sticky until rst.
REQ-034 SHALL verify: frame_len changed from 3 to 5 after word 1 of a frame -> that frame ends at word 2 with tlast; next frame has 5 words.
REQ-035 SHALL verify: rst asserted after 4 nibbles -> all outputs 0 next cycle, subsequent 6 nibbles form a clean word at index 0.
